// File: rtl/mag_avg_detect.sv
// Windowed moving average of magnitude samples, with a hysteretic threshold alarm and a peak hold.
// Result is registered one cycle after the accepting edge; a result held by the consumer blocks new samples.
module mag_avg_detect #(
  parameter int LOG2_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mag_in,
  input  logic       mag_valid,
  output logic       mag_ready,
  output logic [7:0] avg_out,
  output logic       avg_valid,
  input  logic       avg_ready,
  input  logic [7:0] thr_hi,
  input  logic [7:0] thr_lo,
  output logic       alarm,
  output logic [7:0] peak_out,
  input  logic       peak_clr,
  input  logic       restart
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = 8 + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] LAST = '1;

  typedef enum logic {FILL, RUN} state_t;

  state_t                state, state_nxt;
  logic [7:0]            win_mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wptr;
  logic [LOG2_DEPTH-1:0] fill_cnt;
  logic [SW-1:0]         sum;
  logic [SW-1:0]         sum_nxt;
  logic [7:0]            avg_nxt;
  logic                  accept;
  logic                  produce;

  assign mag_ready = !restart && (!avg_valid || avg_ready);
  assign accept    = mag_valid && mag_ready;

  // The sum never exceeds DEPTH*255, so modular SW-bit arithmetic stays exact.
  assign sum_nxt = sum - SW'(win_mem[wptr]) + SW'(mag_in);
  assign avg_nxt = 8'(sum_nxt >> LOG2_DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    produce   = 1'b0;
    case (state)
      FILL: begin
        if (accept && fill_cnt == LAST) begin
          produce   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (accept) produce = 1'b1;
      end
      default: state_nxt = FILL;
    endcase
    if (restart) state_nxt = FILL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) win_mem[i] <= 8'd0;
      sum      <= '0;
      wptr     <= '0;
      fill_cnt <= '0;
    end else if (restart) begin
      for (int i = 0; i < DEPTH; i++) win_mem[i] <= 8'd0;
      sum      <= '0;
      wptr     <= '0;
      fill_cnt <= '0;
    end else if (accept) begin
      win_mem[wptr] <= mag_in;
      sum           <= sum_nxt;
      wptr          <= wptr + 1'b1;
      if (state == FILL) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avg_out   <= 8'd0;
      avg_valid <= 1'b0;
      alarm     <= 1'b0;
    end else if (restart) begin
      avg_valid <= 1'b0;
    end else if (produce) begin
      avg_out   <= avg_nxt;
      avg_valid <= 1'b1;
      // Set wins over clear when the thresholds overlap.
      if (avg_nxt >= thr_hi)     alarm <= 1'b1;
      else if (avg_nxt < thr_lo) alarm <= 1'b0;
    end else if (avg_ready) begin
      avg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_out <= 8'd0;
    end else if (peak_clr) begin
      peak_out <= accept ? mag_in : 8'd0;
    end else if (accept && mag_in > peak_out) begin
      peak_out <= mag_in;
    end
  end

endmodule
